// File: rtl/decimator_pkg.sv
// Shared DFE constants and small helpers for the decimator and its shift/saturate stage.
// The comb stage and later DFE stages import the same values.
package decimator_pkg;

  localparam int unsigned DFE_WINDOW_LEN = 250;
  localparam int unsigned DFE_DECIM      = 250;
  localparam int unsigned DFE_COMB_BW    = 9;
  localparam int unsigned DFE_FEAT_BW    = 8;

  // Counter width that stays at least one bit when only a single state exists.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/decimator_shift_sat.sv
// Combinational arithmetic right shift followed by a clamp to the signed output range.
// Reports whether the clamp changed the value.
module shift_sat #(
  parameter int unsigned I_BW  = 9,
  parameter int unsigned O_BW  = 8,
  parameter int unsigned SHIFT = 1
) (
  input  logic signed [I_BW-1:0] din,
  output logic signed [O_BW-1:0] dout,
  output logic                   clamped
);

  logic signed [I_BW-1:0] wide;

  // Keeps all I_BW bits so the sign copies of the shift take part in the range check.
  assign wide = din >>> SHIFT;

  if (I_BW > O_BW) begin : g_clamp
    logic [I_BW-O_BW:0] top_bits;
    logic               ovf;

    // In range exactly when every bit from the output sign bit upward matches.
    assign top_bits = wide[I_BW-1:O_BW-1];
    assign ovf      = (|top_bits) && !(&top_bits);

    always_comb begin
      dout    = wide[O_BW-1:0];
      clamped = 1'b0;
      if (ovf) begin
        clamped = 1'b1;
        dout    = wide[I_BW-1] ? {1'b1, {(O_BW-1){1'b0}}} : {1'b0, {(O_BW-1){1'b1}}};
      end
    end
  end else begin : g_extend
    assign dout    = O_BW'(wide);
    assign clamped = 1'b0;
  end

endmodule

// File: rtl/decimator.sv
// Keeps one of every DECIM valid comb samples, drops the first STARTUP_SKIP of those,
// then emits the scaled and saturated sample as a one-cycle pulse.
module decimator
  import decimator_pkg::*;
#(
  parameter int unsigned I_BW         = DFE_COMB_BW,
  parameter int unsigned O_BW         = DFE_FEAT_BW,
  parameter int unsigned DECIM        = DFE_DECIM,
  parameter int unsigned SHIFT        = 1,
  parameter int unsigned STARTUP_SKIP = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic signed [I_BW-1:0] data_i,
  input  logic                   valid_i,
  output logic signed [O_BW-1:0] data_o,
  output logic                   valid_o,
  output logic                   sat_o
);

  localparam int unsigned PhaseW = cnt_w(DECIM);
  localparam int unsigned SkipW  = cnt_w(STARTUP_SKIP + 1);

  logic [PhaseW-1:0]     phase_q, phase_d;
  logic [SkipW-1:0]      skip_q, skip_d;
  logic signed [O_BW-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  sat_q, sat_d;

  logic                  clear;
  logic                  dec_pt;
  logic                  skip_done;
  logic signed [O_BW-1:0] scaled;
  logic                  clamped;

  shift_sat #(
    .I_BW  (I_BW),
    .O_BW  (O_BW),
    .SHIFT (SHIFT)
  ) u_shift_sat (
    .din     (data_i),
    .dout    (scaled),
    .clamped (clamped)
  );

  assign clear     = !rst_n_i || !en_i;
  assign dec_pt    = valid_i && (phase_q == PhaseW'(DECIM - 1));
  assign skip_done = (skip_q == SkipW'(STARTUP_SKIP));

  always_comb begin
    phase_d = phase_q;
    skip_d  = skip_q;
    data_d  = data_q;
    valid_d = 1'b0;
    sat_d   = sat_q;

    if (valid_i) begin
      phase_d = dec_pt ? '0 : phase_q + PhaseW'(1);
    end

    if (dec_pt) begin
      if (!skip_done) begin
        skip_d = skip_q + SkipW'(1);
      end else begin
        valid_d = 1'b1;
        data_d  = scaled;
        sat_d   = sat_q || clamped;
      end
    end
  end

  // Clear has priority, so a decimation point coinciding with reset or disable emits nothing.
  always_ff @(posedge clk_i) begin
    if (clear) begin
      phase_q <= '0;
      skip_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      skip_q  <= skip_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sat_o   = sat_q;

endmodule

// File: tb/tb_decimator.sv
// Directed bench for decimator: default configuration plus two short-frame variants
// used for gapped input and saturation behaviour.
module tb_decimator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // u0: defaults (DECIM=250, SHIFT=1, STARTUP_SKIP=1)
  logic              rst0 = 1'b0, en0 = 1'b1, v0 = 1'b0;
  logic signed [8:0] d0 = '0;
  logic signed [7:0] q0;
  logic              vo0, sat0;

  // u1: DECIM=4, SHIFT=1, STARTUP_SKIP=0
  logic              rst1 = 1'b0, en1 = 1'b1, v1 = 1'b0;
  logic signed [8:0] d1 = '0;
  logic signed [7:0] q1;
  logic              vo1, sat1;

  // u2: DECIM=4, SHIFT=0, STARTUP_SKIP=0
  logic              rst2 = 1'b0, en2 = 1'b1, v2 = 1'b0;
  logic signed [8:0] d2 = '0;
  logic signed [7:0] q2;
  logic              vo2, sat2;

  decimator u0 (
    .clk_i(clk), .rst_n_i(rst0), .en_i(en0), .data_i(d0), .valid_i(v0),
    .data_o(q0), .valid_o(vo0), .sat_o(sat0)
  );

  decimator #(.DECIM(4), .SHIFT(1), .STARTUP_SKIP(0)) u1 (
    .clk_i(clk), .rst_n_i(rst1), .en_i(en1), .data_i(d1), .valid_i(v1),
    .data_o(q1), .valid_o(vo1), .sat_o(sat1)
  );

  decimator #(.DECIM(4), .SHIFT(0), .STARTUP_SKIP(0)) u2 (
    .clk_i(clk), .rst_n_i(rst2), .en_i(en2), .data_i(d2), .valid_i(v2),
    .data_o(q2), .valid_o(vo2), .sat_o(sat2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed1(input logic signed [8:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      v1 = 1'b1;
      d1 = d;
      tick();
    end
    v1 = 1'b0;
  endtask

  task automatic feed2(input logic signed [8:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      v2 = 1'b1;
      d2 = d;
      tick();
    end
    v2 = 1'b0;
  endtask

  task automatic test_reset;
    rst0 = 1'b0;
    v0   = 1'b1;
    d0   = 9'sd100;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (q0 !== 8'sd0) begin
      n_bad++; $display("FAIL reset_data: got %0d want 0", q0);
    end
    n_cmp++;
    if (vo0 !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b want 0", vo0);
    end
    n_cmp++;
    if (sat0 !== 1'b0) begin
      n_bad++; $display("FAIL reset_sat: got %b want 0", sat0);
    end
  endtask

  task automatic test_basic_rate;
    logic exp_v;
    rst0 = 1'b1;
    d0   = 9'sd100;
    for (int i = 1; i <= 760; i++) begin
      v0 = 1'b1;
      tick();
      exp_v = (i == 500) || (i == 750);
      n_cmp++;
      if (vo0 !== exp_v) begin
        n_bad++; $display("FAIL basic_valid at valid #%0d: got %b want %b", i, vo0, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (q0 !== 8'sd50) begin
          n_bad++; $display("FAIL basic_data at valid #%0d: got %0d want 50", i, q0);
        end
      end
    end
    n_cmp++;
    if (sat0 !== 1'b0) begin
      n_bad++; $display("FAIL basic_sat: got %b want 0", sat0);
    end
  endtask

  task automatic test_enable_clear;
    logic exp_v;
    // Phase sits at 10 here; a single disabled cycle must discard it and restart the skip.
    en0 = 1'b0;
    v0  = 1'b1;
    tick();
    n_cmp++;
    if (vo0 !== 1'b0 || q0 !== 8'sd0) begin
      n_bad++; $display("FAIL en_clear: got valid=%b data=%0d want 0/0", vo0, q0);
    end
    en0 = 1'b1;
    d0  = -9'sd20;
    for (int i = 1; i <= 500; i++) begin
      tick();
      exp_v = (i == 500);
      n_cmp++;
      if (vo0 !== exp_v) begin
        n_bad++; $display("FAIL en_restart_valid at valid #%0d: got %b want %b", i, vo0, exp_v);
      end
    end
    n_cmp++;
    if (q0 !== -8'sd10) begin
      n_bad++; $display("FAIL en_restart_data: got %0d want -10", q0);
    end
    v0 = 1'b0;
    tick();
    n_cmp++;
    if (vo0 !== 1'b0 || q0 !== -8'sd10) begin
      n_bad++; $display("FAIL hold_data: got valid=%b data=%0d want 0/-10", vo0, q0);
    end
  endtask

  task automatic test_reset_at_decim;
    rst0 = 1'b0;
    tick();
    rst0 = 1'b1;
    d0   = 9'sd100;
    for (int i = 1; i <= 499; i++) begin
      v0 = 1'b1;
      tick();
    end
    n_cmp++;
    if (vo0 !== 1'b0) begin
      n_bad++; $display("FAIL pre_decim_valid: got %b want 0", vo0);
    end
    rst0 = 1'b0;
    tick();
    n_cmp++;
    if (vo0 !== 1'b0 || q0 !== 8'sd0) begin
      n_bad++; $display("FAIL reset_at_decim: got valid=%b data=%0d want 0/0", vo0, q0);
    end
    v0   = 1'b0;
    rst0 = 1'b1;
  endtask

  task automatic test_gapped;
    int            k;
    logic          exp_v;
    logic signed [7:0] exp_d;
    rst1 = 1'b0;
    tick();
    rst1 = 1'b1;
    k = 0;
    for (int c = 0; c < 36; c++) begin
      v1 = (c % 3 == 0);
      if (v1) begin
        k++;
        d1 = 9'(10 * k);
      end
      tick();
      exp_v = v1 && (k % 4 == 0);
      exp_d = 8'(5 * k);
      n_cmp++;
      if (vo1 !== exp_v) begin
        n_bad++; $display("FAIL gap_valid at cycle %0d: got %b want %b", c, vo1, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (q1 !== exp_d) begin
          n_bad++; $display("FAIL gap_data at valid #%0d: got %0d want %0d", k, q1, exp_d);
        end
      end
    end
    v1 = 1'b0;
  endtask

  task automatic test_shift_floor;
    feed1(9'sd255, 4);
    n_cmp++;
    if (vo1 !== 1'b1 || q1 !== 8'sd127 || sat1 !== 1'b0) begin
      n_bad++; $display("FAIL shift_255: got v=%b d=%0d s=%b want 1/127/0", vo1, q1, sat1);
    end
    feed1(-9'sd3, 4);
    n_cmp++;
    if (vo1 !== 1'b1 || q1 !== -8'sd2) begin
      n_bad++; $display("FAIL neg_floor: got v=%b d=%0d want 1/-2", vo1, q1);
    end
    feed1(-9'sd256, 4);
    n_cmp++;
    if (q1 !== -8'sd128 || sat1 !== 1'b0) begin
      n_bad++; $display("FAIL shift_min: got d=%0d s=%b want -128/0", q1, sat1);
    end
  endtask

  task automatic test_saturation;
    rst2 = 1'b0;
    tick();
    rst2 = 1'b1;
    feed2(9'sd200, 4);
    n_cmp++;
    if (vo2 !== 1'b1 || q2 !== 8'sd127 || sat2 !== 1'b1) begin
      n_bad++; $display("FAIL sat_pos: got v=%b d=%0d s=%b want 1/127/1", vo2, q2, sat2);
    end
    feed2(9'sd5, 4);
    n_cmp++;
    if (q2 !== 8'sd5 || sat2 !== 1'b1) begin
      n_bad++; $display("FAIL sat_sticky: got d=%0d s=%b want 5/1", q2, sat2);
    end
    feed2(-9'sd256, 4);
    n_cmp++;
    if (q2 !== -8'sd128 || sat2 !== 1'b1) begin
      n_bad++; $display("FAIL sat_neg: got d=%0d s=%b want -128/1", q2, sat2);
    end
    en2 = 1'b0;
    tick();
    en2 = 1'b1;
    n_cmp++;
    if (sat2 !== 1'b0 || q2 !== 8'sd0) begin
      n_bad++; $display("FAIL sat_clear: got d=%0d s=%b want 0/0", q2, sat2);
    end
  endtask

  initial begin
    test_reset();
    test_basic_rate();
    test_enable_clear();
    test_reset_at_decim();
    test_gapped();
    test_shift_floor();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
